// File: rtl/audio_sample_shuttle.sv
// Per-sample shuttle between the codec FIFOs and the filter stage, with a write timeout and drop counter.
// Optional peak meter on written samples is enabled by defining AUDIO_SHUTTLE_PEAK_METER_EN.
module audio_sample_shuttle #(
    parameter int SETTLE_CYCLES = 4,
    parameter int WRITE_TIMEOUT = 2048
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        read_ready,
    input  logic        write_ready,
    input  logic [31:0] codec_left_in,
    input  logic [31:0] codec_right_in,
    output logic        read,
    output logic        write,
    output logic [31:0] left_channel_audio_in,
    output logic [31:0] right_channel_audio_in,
    input  logic [1:0]  filter_choice_req,
    output logic [1:0]  filter_choice,
    input  logic [31:0] left_channel_audio_out,
    input  logic [31:0] right_channel_audio_out,
    output logic [31:0] codec_left_out,
    output logic [31:0] codec_right_out,
    output logic [15:0] sample_count,
    output logic [7:0]  overrun_count,
    output logic        busy,
    input  logic        peak_clear,
    output logic [31:0] peak_left,
    output logic [31:0] peak_right
);
    typedef enum logic [2:0] {IDLE, READ, SETTLE, WAIT_WR, WRITE} state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(WRITE_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  settle_cnt_reg, settle_cnt_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        latch_in, capture_out, overrun;

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        latch_in        = 1'b0;
        capture_out     = 1'b0;
        overrun         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (read_ready) state_next = READ;
            end
            READ: begin
                latch_in        = 1'b1;
                settle_cnt_next = '0;
                state_next      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    capture_out   = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = WAIT_WR;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 8'd1;
                end
            end
            WAIT_WR: begin
                // write_ready is checked first so a late grant on the limit cycle still writes
                if (write_ready) begin
                    state_next = WRITE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    overrun    = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_reg              <= IDLE;
            settle_cnt_reg         <= '0;
            wait_cnt_reg           <= '0;
            read                   <= 1'b0;
            write                  <= 1'b0;
            busy                   <= 1'b0;
            left_channel_audio_in  <= '0;
            right_channel_audio_in <= '0;
            filter_choice          <= 2'b00;
            codec_left_out         <= '0;
            codec_right_out        <= '0;
            sample_count           <= '0;
            overrun_count          <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            read           <= (state_next == READ);
            write          <= (state_next == WRITE);
            busy           <= (state_next != IDLE);
            if (latch_in) begin
                left_channel_audio_in  <= codec_left_in;
                right_channel_audio_in <= codec_right_in;
                filter_choice          <= filter_choice_req;
            end
            if (capture_out) begin
                codec_left_out  <= left_channel_audio_out;
                codec_right_out <= right_channel_audio_out;
            end
            if (state_next == WRITE && state_reg != WRITE) begin
                sample_count <= sample_count + 16'd1;
            end
            if (overrun && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

`ifdef AUDIO_SHUTTLE_PEAK_METER_EN
    logic [31:0] sample_out [2];
    assign sample_out[0] = codec_left_out;
    assign sample_out[1] = codec_right_out;

    for (genvar gi = 0; gi < 2; gi++) begin : g_peak
        logic [31:0] mag;
        logic [31:0] peak_reg;

        // |x| with the most negative value clamped to the largest positive one
        always_comb begin
            mag = sample_out[gi];
            if (sample_out[gi][31]) begin
                mag = (sample_out[gi] == 32'h8000_0000) ? 32'h7FFF_FFFF : (32'd0 - sample_out[gi]);
            end
        end

        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                peak_reg <= '0;
            end else if (peak_clear) begin
                peak_reg <= '0;
            end else if (state_reg == WRITE && mag > peak_reg) begin
                peak_reg <= mag;
            end
        end
    end

    assign peak_left  = g_peak[0].peak_reg;
    assign peak_right = g_peak[1].peak_reg;
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peak_clear;
    assign peak_left         = '0;
    assign peak_right        = '0;
`endif
endmodule

// File: tb/tb_audio_sample_shuttle.sv
// Randomized transaction-level bench for audio_sample_shuttle with a behavioural scoreboard.
`timescale 1ns/1ps
module tb_audio_sample_shuttle;
    localparam int S  = 4;
    localparam int WT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_ready = 1'b0, write_ready = 1'b0;
    logic [31:0] codec_left_in = '0, codec_right_in = '0;
    logic        read, write, busy;
    logic [31:0] left_channel_audio_in, right_channel_audio_in;
    logic [1:0]  filter_choice_req = 2'b00, filter_choice;
    logic [31:0] left_channel_audio_out, right_channel_audio_out;
    logic [31:0] codec_left_out, codec_right_out;
    logic [15:0] sample_count;
    logic [7:0]  overrun_count;
    logic        peak_clear = 1'b0;
    logic [31:0] peak_left, peak_right;

    int checks = 0, failures = 0, cyc = 0;
    bit both_err = 0;

    // scoreboard state
    int          m_samples = 0, m_overruns = 0;
    logic [1:0]  m_choice = 2'b00;
    logic [31:0] m_peak_l = '0, m_peak_r = '0;

    // filter stub: pass-through offset by the selected filter number
    assign left_channel_audio_out  = left_channel_audio_in + 32'(filter_choice);
    assign right_channel_audio_out = right_channel_audio_in + 32'(filter_choice);

    audio_sample_shuttle #(.SETTLE_CYCLES(S), .WRITE_TIMEOUT(WT)) dut (
        .CLOCK_50(clk), .reset(reset),
        .read_ready(read_ready), .write_ready(write_ready),
        .codec_left_in(codec_left_in), .codec_right_in(codec_right_in),
        .read(read), .write(write),
        .left_channel_audio_in(left_channel_audio_in), .right_channel_audio_in(right_channel_audio_in),
        .filter_choice_req(filter_choice_req), .filter_choice(filter_choice),
        .left_channel_audio_out(left_channel_audio_out), .right_channel_audio_out(right_channel_audio_out),
        .codec_left_out(codec_left_out), .codec_right_out(codec_right_out),
        .sample_count(sample_count), .overrun_count(overrun_count), .busy(busy),
        .peak_clear(peak_clear), .peak_left(peak_left), .peak_right(peak_right)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (read && write) both_err = 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mag32(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s < 0) s = -s;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        return 32'(s);
    endfunction

    task automatic check_zero_state(input string tag);
        check_val({tag, "_ctl"}, {29'd0, read, write, busy}, 32'd0);
        check_val({tag, "_fc"}, 32'(filter_choice), 32'd0);
        check_val({tag, "_in"}, left_channel_audio_in | right_channel_audio_in, 32'd0);
        check_val({tag, "_out"}, codec_left_out | codec_right_out, 32'd0);
        check_val({tag, "_cnt"}, {8'd0, overrun_count, sample_count}, 32'd0);
        check_val({tag, "_peak"}, peak_left | peak_right, 32'd0);
    endtask

    // One sample transaction; write_ready rises d cycles into the write wait (d >= WT never grants)
    task automatic run_sample(input logic [31:0] l, input logic [31:0] r, input logic [1:0] ch, input int d);
        int  k, t, wcyc, icyc;
        bit  seen, idle_back, expect_wr;
        logic [31:0] el, er;
        expect_wr = (d < WT);
        @(negedge clk);
        codec_left_in = l; codec_right_in = r; filter_choice_req = ch;
        read_ready = 1'b1; write_ready = 1'b0;
        t = 0;
        while (!read && t < 20) begin @(negedge clk); t++; end
        check_val("read_seen", 32'(read), 32'd1);
        check_val("fc_before_read", 32'(filter_choice), 32'(m_choice));
        k = cyc;
        read_ready = 1'b0;
        @(negedge clk);
        check_val("latch_left", left_channel_audio_in, l);
        check_val("latch_right", right_channel_audio_in, r);
        check_val("latch_fc", 32'(filter_choice), 32'(ch));
        m_choice = ch;
        codec_left_in = $urandom; codec_right_in = $urandom; filter_choice_req = 2'($urandom);
        el = l + 32'(ch); er = r + 32'(ch);
        seen = 0; idle_back = 0; wcyc = 0; icyc = 0;
        for (int i = 0; i < S + WT + 10; i++) begin
            if (cyc >= k + S + 1 + d) write_ready = 1'b1;
            if (write) begin seen = 1; wcyc = cyc; break; end
            if (!busy) begin idle_back = 1; icyc = cyc; break; end
            @(negedge clk);
        end
        check_val("txn_bounded", 32'(seen | idle_back), 32'd1);
        check_val("write_expected", 32'(seen), 32'(expect_wr));
        check_val("fc_held", 32'(filter_choice), 32'(ch));
        check_val("out_left", codec_left_out, el);
        check_val("out_right", codec_right_out, er);
        if (seen) begin
            check_val("write_latency", 32'(wcyc - k), 32'(S + 2 + d));
            m_samples = (m_samples + 1) % 65536;
`ifdef AUDIO_SHUTTLE_PEAK_METER_EN
            if (mag32(el) > m_peak_l) m_peak_l = mag32(el);
            if (mag32(er) > m_peak_r) m_peak_r = mag32(er);
`endif
            @(negedge clk);
            check_val("idle_after_write", 32'(busy), 32'd0);
        end else if (idle_back) begin
            check_val("timeout_cycle", 32'(icyc - k), 32'(S + 1 + WT));
            if (m_overruns < 255) m_overruns++;
        end
        write_ready = 1'b0;
        check_val("sample_count", 32'(sample_count), 32'(m_samples));
        check_val("overrun_count", 32'(overrun_count), 32'(m_overruns));
        check_val("peak_left", peak_left, m_peak_l);
        check_val("peak_right", peak_right, m_peak_r);
        $display("txn l=%h r=%h ch=%0d d=%0d wrote=%0d samples=%0d overruns=%0d",
                 l, r, ch, d, seen, sample_count, overrun_count);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero_state("reset");
        reset = 1'b1;

        run_sample(32'h0000_1234, 32'h0000_5678, 2'b00, 0);
        run_sample($urandom, $urandom, 2'b10, 0);
        for (int n = 0; n < 20; n++)
            run_sample($urandom, $urandom, 2'($urandom), int'($urandom_range(0, 8)));
        run_sample($urandom, $urandom, 2'($urandom), WT - 1);
        run_sample($urandom, $urandom, 2'($urandom), WT);

        // asynchronous reset in the middle of SETTLE
        @(negedge clk);
        codec_left_in = 32'hDEAD_BEEF; codec_right_in = 32'h0BAD_F00D;
        filter_choice_req = 2'b11; read_ready = 1'b1;
        for (int t = 0; t < 20 && !read; t++) @(negedge clk);
        read_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero_state("mid_reset");
        m_samples = 0; m_overruns = 0; m_choice = 2'b00; m_peak_l = '0; m_peak_r = '0;
        @(negedge clk);
        reset = 1'b1;
        run_sample(32'h0000_00AA, 32'h0000_0055, 2'b01, 1);

        for (int n = 0; n < 300; n++)
            run_sample($urandom, $urandom, 2'($urandom), WT + 5);
        check_val("overrun_saturated", 32'(overrun_count), 32'd255);

        run_sample(32'hFFFF_FFFB, 32'd7, 2'b00, 0);
        run_sample(32'd3, 32'hFFFF_FFF0, 2'b00, 2);
        run_sample(32'h8000_0000, 32'd1, 2'b00, 0);
        @(negedge clk);
        peak_clear = 1'b1;
        @(negedge clk);
        peak_clear = 1'b0;
        m_peak_l = '0; m_peak_r = '0;
        check_val("peak_clear_l", peak_left, m_peak_l);
        check_val("peak_clear_r", peak_right, m_peak_r);

        check_val("rw_exclusive", 32'(both_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_sample_shuttle.md
Name: audio_sample_shuttle

Overview:
- Per-sample transfer controller between the audio codec core and the filter-select stage.
- Reads one stereo sample from the codec FIFO when available and holds it steady on the filter inputs.
- Waits a fixed settle time, captures the filtered result, then writes it back to the codec output FIFO.
- Also re-times the user filter selection so it only changes at sample boundaries, and counts dropped samples.

Parameters:
SETTLE_CYCLES, 4, cycles the filtered output is allowed to settle before capture (legal range 1..255)
WRITE_TIMEOUT, 2048, cycles spent waiting for write_ready before the sample is dropped (legal range 1..65535)

Ports:
CLOCK_50  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
read_ready  in  1  codec input FIFO holds a sample
write_ready  in  1  codec output FIFO has room
codec_left_in  in  32  codec left sample
codec_right_in  in  32  codec right sample
read  out  1  one-cycle pop strobe to the codec
write  out  1  one-cycle push strobe to the codec
left_channel_audio_in  out  32  held left sample sent to the filter stage
right_channel_audio_in  out  32  held right sample sent to the filter stage
filter_choice_req  in  2  raw user filter selection
filter_choice  out  2  boundary-aligned filter selection sent to the filter stage
left_channel_audio_out  in  32  filtered left sample
right_channel_audio_out  in  32  filtered right sample
codec_left_out  out  32  left sample presented to the codec
codec_right_out  out  32  right sample presented to the codec
sample_count  out  16  completed writes
overrun_count  out  8  dropped samples
busy  out  1  high in every state except IDLE
peak_clear  in  1  clears the peak registers (optional feature)
peak_left  out  32  left peak magnitude (optional feature)
peak_right  out  32  right peak magnitude (optional feature)

Behaviour:
- Reset (reset=0, asynchronous) takes effect immediately, including mid-operation; any in-flight sample is discarded.
  - State goes to IDLE.
  - All outputs go to 0, filter_choice=2'b00 (bypass), read=write=0.
- All outputs are registered.
- FSM states: IDLE, READ, SETTLE, WAIT_WR, WRITE.
- IDLE: if read_ready=1, go to READ; otherwise stay in IDLE.
- READ: read=1 for exactly this one cycle. On the edge ending READ:
  - latch codec_left_in/right_in into left/right_channel_audio_in;
  - latch filter_choice_req into filter_choice;
  - go to SETTLE.
- SETTLE: a counter runs SETTLE_CYCLES cycles. On the edge ending the last cycle:
  - capture left/right_channel_audio_out into codec_left_out/right_out;
  - go to WAIT_WR.
- WAIT_WR:
  - if write_ready=1, go to WRITE;
  - else increment the timeout counter; when it reaches WRITE_TIMEOUT, go to IDLE and increment overrun_count.
  - If write_ready=1 in the same cycle the limit is reached, WRITE wins and no overrun is counted.
- WRITE: write=1 for exactly one cycle; sample_count increments; go to IDLE.
- Minimum latency: read high in cycle k gives write high in cycle k+SETTLE_CYCLES+2.
- Back-to-back: read_ready held at 1 gives one sample per SETTLE_CYCLES+4 cycles (IDLE is always visited).
- Held values:
  - left/right_channel_audio_in and filter_choice are constant between READ strobes;
  - codec_left_out/right_out are constant from capture until the next capture.
- Changes on filter_choice_req outside READ are ignored until the next READ.
- sample_count wraps from 16'hFFFF to 0.
- overrun_count saturates at 8'hFF.
- read and write are never high in the same cycle.

Optional Feature:
- Macro: AUDIO_SHUTTLE_PEAK_METER_EN.
- With the macro defined:
  - on each WRITE, peak_left/right = max(current peak, |codec_left_out| / |codec_right_out|);
  - the magnitude is a two's-complement absolute value; -2^31 saturates to 32'h7FFFFFFF;
  - peak_clear=1 zeroes both peaks on the next edge, and overrides a same-cycle update;
  - reset value is 0.
- Without the macro: the peak_clear, peak_left and peak_right ports remain; the peak outputs are tied to 0 and peak_clear is ignored.

Test Plan:
- Pulse read_ready with codec_left_in=32'h00001234, filter stub passing data through, write_ready=1 -> read in cycle k; write in cycle k+6 (default SETTLE_CYCLES); codec_left_out=32'h00001234; sample_count=1.
- Change filter_choice_req 00->10 during SETTLE -> filter_choice stays 00 until the next READ edge, then becomes 10.
- Hold write_ready=0 for 2048 cycles after capture -> return to IDLE, no write pulse, overrun_count=1; repeat 300 times -> overrun_count=255.
- Raise write_ready on the exact cycle the timeout counter hits its limit -> write pulses and overrun_count is unchanged.
- Assert reset=0 during SETTLE -> immediately read=write=0, busy=0, all outputs 0; after release, the next sample completes normally.
- With AUDIO_SHUTTLE_PEAK_METER_EN defined, write -5 then 3 then 32'h80000000 on left -> peak_left 5, 5, then 32'h7FFFFFFF; pulse peak_clear -> 0.
